instn_encode: RTL
=================

INSTN_ENCODE -- requirements
Module: instn_encode

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, meaning the first word address written after each start.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins a load session.
REQ-006 SHALL have ports in_valid, input, 1 bit, and in_ready, output, 1 bit: the field-input handshake.
REQ-007 SHALL have port in_last, input, 1 bit: marks the final instruction of the session.
REQ-008 SHALL have port fmt, input, 3 bits: instruction format, encoded R=0, I=1, S=2, B=3, U=4, J=5; values 6-7 are illegal.
REQ-009 SHALL have input ports op (7 bits), funct3 (3), funct7 (7), rd (5), rs1 (5), rs2 (5) and imm (32): the instruction fields.
REQ-010 SHALL have ports imem_we, output, 1 bit, and imem_ready, input, 1 bit: the write handshake toward the instruction memory.
REQ-011 SHALL have ports imem_addr, output, ADDR_W bits, and imem_wdata, output, 32 bits: the write address and the encoded word.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a session.
REQ-013 SHALL have port err, output, 1 bit: sticky error flag, cleared by start.

Function
REQ-014 SHALL implement states IDLE, LOAD, DRAIN and FIN, with these transitions:
- IDLE to LOAD on start.
- LOAD to DRAIN when an in_last beat is accepted.
- DRAIN to FIN when the output register is empty.
- FIN to IDLE unconditionally.
REQ-015 SHALL drive in_ready = (state==LOAD) && (!imem_we || imem_ready).
REQ-016 SHALL register each accepted beat into a one-entry output register.
- imem_we rises the cycle after acceptance, giving 1-cycle latency.
REQ-017 SHALL hold imem_we, imem_addr and imem_wdata stable while imem_we=1 and imem_ready=0.
REQ-018 SHALL advance imem_addr by 1, modulo 2^ADDR_W, on each imem_we && imem_ready cycle.
- It wraps from 2^ADDR_W-1 to 0.
REQ-019 SHALL load imem_addr with BASE_ADDR and clear err on start, accepted in IDLE only; start in any other state SHALL be ignored.
REQ-020 SHALL place the common fields as follows: op at [6:0]; rd at [11:7] (R/I/U/J); funct3 at [14:12] (R/I/S/B); rs1 at [19:15] (R/I/S/B); rs2 at [24:20] (R/S/B).
REQ-021 SHALL encode the format-specific bits as follows:
- R: funct7 at [31:25].
- I: imm[11:0] at [31:20].
- S: imm[11:5] at [31:25] and imm[4:0] at [11:7].
- B: imm[12], imm[10:5], imm[4:1], imm[11] at [31], [30:25], [11:8], [7].
- U: imm[31:12] at [31:12].
- J: imm[20], imm[10:1], imm[11], imm[19:12] at [31], [30:21], [20], [19:12].
REQ-022 SHALL, for an illegal fmt, write 0x00000013 (NOP) and set err.
REQ-023 SHALL pulse done for exactly one cycle in FIN.
REQ-024 SHALL allow simultaneous accept-in and write-out in the same cycle without a bubble.

Reset
REQ-025 SHALL, while rst_n=0, force the following regardless of clk, including mid-session (any partially written word is dropped):
- state=IDLE, imem_we=0, in_ready=0, done=0, err=0.
- imem_addr=BASE_ADDR, imem_wdata=0.

Configuration
REQ-026 SHALL, with IMM_CHECK_EN defined, set err on an accepted beat in any of these cases, still writing the truncated encoding:
- I or S: imm[31:11] is not all-equal.
- B: imm outside -4096..4094, or imm[0]=1.
- J: imm outside +/-1 MiB, or imm[0]=1.
- U: imm[11:0] != 0.
REQ-027 SHALL, without IMM_CHECK_EN, truncate immediates silently, with err set only by an illegal fmt.

Structure
REQ-028 SHALL take the fmt enumeration, the state enumeration, the NOP constant and the opcode constants from a shared package riscv_pkg.
REQ-029 SHALL use one combinational sub-module, instn_pack, that maps fields to the 32-bit word; the FSM, counter and register stay in instn_encode.

Verification
REQ-030 SHALL cover: I, op=0x13, rd=1, rs1=0, imm=5 -> imem_wdata=0x00500093 at addr 0, one cycle after accept.
REQ-031 SHALL cover: S, op=0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423; J, op=0x6F, rd=1, imm=8 -> 0x008000EF.
REQ-032 SHALL cover: B, op=0x63, f3=0, imm=-4 -> 0xFE000EE3; U, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-033 SHALL cover: imem_ready=0 for 3 cycles with a word pending -> in_ready=0 and outputs held; release -> the write completes and the next beat is accepted in the same cycle.
REQ-034 SHALL cover: ADDR_W=2 with 5 words, last flagged -> addresses 0,1,2,3,0, then a done pulse 1 cycle after the final write.
REQ-035 SHALL cover: rst_n low mid-DRAIN -> imem_we=0 immediately, IDLE; fmt=7 -> NOP written and err=1; with IMM_CHECK_EN, B imm=3 -> err=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction formats, encoder FSM
// states, opcode constants and the canonical NOP.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = {25'd0, OPC_IMM};

  // True when every bit selected by mask is equal, i.e. the value is a
  // correctly sign-extended immediate of the width left unmasked.
  function automatic logic upper_same(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == mask) || ((v & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/instn_pack.sv
// Combinational field-to-word packer for RV32 base formats.
// Optional IMM_CHECK_EN flags immediates that do not fit their format.
module instn_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        fmt_bad,
  output logic        imm_bad
);

  fmt_e f;
  assign f = fmt_e'(fmt);

  // Place common and format-specific fields; illegal formats become a NOP.
  always_comb begin
    word    = 32'd0;
    fmt_bad = 1'b0;
    word[6:0] = op;
    case (f)
      FMT_R: begin
        word[11:7]  = rd;
        word[14:12] = funct3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[31:25] = funct7;
      end
      FMT_I: begin
        word[11:7]  = rd;
        word[14:12] = funct3;
        word[19:15] = rs1;
        word[31:20] = imm[11:0];
      end
      FMT_S: begin
        word[11:7]  = imm[4:0];
        word[14:12] = funct3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[31:25] = imm[11:5];
      end
      FMT_B: begin
        word[7]     = imm[11];
        word[11:8]  = imm[4:1];
        word[14:12] = funct3;
        word[19:15] = rs1;
        word[24:20] = rs2;
        word[30:25] = imm[10:5];
        word[31]    = imm[12];
      end
      FMT_U: begin
        word[11:7]  = rd;
        word[31:12] = imm[31:12];
      end
      FMT_J: begin
        word[11:7]  = rd;
        word[19:12] = imm[19:12];
        word[20]    = imm[11];
        word[30:21] = imm[10:1];
        word[31]    = imm[20];
      end
      default: begin
        word    = NOP;
        fmt_bad = 1'b1;
      end
    endcase
  end

`ifdef IMM_CHECK_EN
  // Flag immediates that lose information when truncated into the word.
  always_comb begin
    imm_bad = 1'b0;
    case (f)
      FMT_I, FMT_S: imm_bad = !upper_same(imm, 32'hFFFF_F800);
      FMT_B:        imm_bad = !upper_same(imm, 32'hFFFF_F000) || imm[0];
      FMT_J:        imm_bad = !upper_same(imm, 32'hFFF0_0000) || imm[0];
      FMT_U:        imm_bad = |imm[11:0];
      default:      imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

endmodule

// File: rtl/instn_encode.sv
// Instruction encoder/loader: accepts field beats, packs them into RV32
// words and streams them into instruction memory at consecutive addresses.
// Optional build macro: IMM_CHECK_EN (immediate range checking -> err).
module instn_encode
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        fmt,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  state_e      state, state_nx;
  logic [31:0] word;
  logic        fmt_bad, imm_bad;
  logic        accept, wr_fire, start_ok, slot_free;

  instn_pack u_pack (
    .fmt     (fmt),
    .op      (op),
    .funct3  (funct3),
    .funct7  (funct7),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .word    (word),
    .fmt_bad (fmt_bad),
    .imm_bad (imm_bad)
  );

  // The output register frees up this cycle if empty or being written out,
  // which lets a new beat land in the same cycle the old one leaves.
  assign slot_free = !imem_we || imem_ready;
  assign wr_fire   = imem_we && imem_ready;
  assign in_ready  = (state == LOAD) && slot_free;
  assign accept    = in_valid && in_ready;
  assign start_ok  = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and done pulse. DRAIN leaves as soon as the last word is
  // leaving the register, so done follows the final write by one cycle.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = LOAD;
      LOAD:  if (accept && in_last) state_nx = DRAIN;
      DRAIN: if (slot_free) state_nx = FIN;
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One-entry output register; holds while the memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_wdata <= 32'd0;
    end else if (accept) begin
      imem_we    <= 1'b1;
      imem_wdata <= word;
    end else if (wr_fire) begin
      imem_we    <= 1'b0;
    end
  end

  // Write address: rebased on start, advanced per completed write (wraps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       imem_addr <= BASE_A;
    else if (start_ok) imem_addr <= BASE_A;
    else if (wr_fire)  imem_addr <= imem_addr + ADDR_W'(1);
  end

  // Sticky error, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err <= 1'b0;
    else if (start_ok)                        err <= 1'b0;
    else if (accept && (fmt_bad || imm_bad))  err <= 1'b1;
  end

endmodule
